// File: rtl/cpu_clock_ctrl.sv
`timescale 1ns/1ps
// CPU clock controller: even divider of main_clk with run/halt/single-step control,
// glitch-free divide-ratio reload, rising-edge tick and CPU cycle counter.
module cpu_clock_ctrl #(
    parameter int HALF_W       = 8,
    parameter int DEFAULT_HALF = 1,
    parameter int CNT_W        = 32,
    parameter bit RESET_RUN    = 1'b1
) (
    input  logic              main_clk,
    input  logic              resetn,
    output logic              mem_clk,
    output logic              clock_out,
    output logic              cpu_tick,
    input  logic              run_req,
    input  logic              step_req,
    input  logic [HALF_W-1:0] half_in,
    input  logic              half_load,
    output logic              halted,
    output logic [HALF_W-1:0] cur_half,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOPPING,
        ST_HALT,
        ST_STEP
    } state_t;

    localparam logic [HALF_W-1:0] RESET_HALF =
        (DEFAULT_HALF == 0) ? HALF_W'(1) : HALF_W'(DEFAULT_HALF);
    localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_t            state, state_nxt;
    logic [HALF_W-1:0] div_cnt, cnt_nxt;
    logic              clk_nxt;
    logic              tick_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [HALF_W-1:0] half_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic [HALF_W-1:0] pend_val, pend_val_nxt;
    logic [HALF_W-1:0] half_in_fixed;
    logic              boundary;
    logic              rise_edge;
    logic              fall_edge;
    logic              divide;

    assign mem_clk       = main_clk;
    assign halted        = (state == ST_HALT) && !clock_out;
    assign half_in_fixed = (half_in == '0) ? HALF_W'(1) : half_in;
    assign boundary      = (div_cnt == (cur_half - HALF_W'(1)));
    assign rise_edge     = boundary && !clock_out;
    assign fall_edge     = boundary && clock_out;

    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RESET_STATE;
            div_cnt     <= '0;
            clock_out   <= 1'b0;
            cpu_tick    <= 1'b0;
            cycle_count <= '0;
            cur_half    <= RESET_HALF;
            pend_valid  <= 1'b0;
            pend_val    <= RESET_HALF;
        end else begin
            state       <= state_nxt;
            div_cnt     <= cnt_nxt;
            clock_out   <= clk_nxt;
            cpu_tick    <= tick_nxt;
            cycle_count <= count_nxt;
            cur_half    <= half_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_val    <= pend_val_nxt;
        end
    end

    // STOPPING halts only where the next rising edge would have been, so phases stay whole.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = div_cnt;
        clk_nxt        = clock_out;
        tick_nxt       = 1'b0;
        count_nxt      = cycle_count;
        half_nxt       = cur_half;
        pend_valid_nxt = pend_valid;
        pend_val_nxt   = pend_val;
        divide         = 1'b0;

        case (state)
            ST_RUN: begin
                divide = 1'b1;
                if (!run_req) begin
                    state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (run_req) begin
                    divide    = 1'b1;
                    state_nxt = ST_RUN;
                end else if (rise_edge) begin
                    state_nxt = ST_HALT;
                    cnt_nxt   = '0;
                end else begin
                    divide = 1'b1;
                end
            end
            ST_HALT: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (run_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
                if (pend_valid) begin
                    half_nxt       = pend_val;
                    pend_valid_nxt = 1'b0;
                end
            end
            ST_STEP: begin
                divide = 1'b1;
                if (fall_edge) begin
                    state_nxt = run_req ? ST_RUN : ST_HALT;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase

        // A new ratio only takes effect at a falling boundary, where the counter restarts.
        if (divide) begin
            if (boundary) begin
                cnt_nxt = '0;
                clk_nxt = !clock_out;
                if (!clock_out) begin
                    tick_nxt  = 1'b1;
                    count_nxt = cycle_count + CNT_W'(1);
                end else if (pend_valid) begin
                    half_nxt       = pend_val;
                    pend_valid_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = div_cnt + HALF_W'(1);
            end
        end

        if (half_load) begin
            pend_val_nxt   = half_in_fixed;
            pend_valid_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
`timescale 1ns/1ps
// Bench for cpu_clock_ctrl: expected per-cycle clock_out/cpu_tick/halted/cycle_count
// are queued from each scenario and compared cycle by cycle against the DUT.
module tb_cpu_clock_ctrl;

    logic        main_clk = 1'b0;
    logic        resetn   = 1'b0;
    logic        mem_clk;
    logic        clock_out;
    logic        cpu_tick;
    logic        run_req   = 1'b1;
    logic        step_req  = 1'b0;
    logic [7:0]  half_in   = 8'd0;
    logic        half_load = 1'b0;
    logic        halted;
    logic [7:0]  cur_half;
    logic [31:0] cycle_count;

    logic        mem_clk_b;
    logic        clock_out_b;
    logic        cpu_tick_b;
    logic        run_req_b   = 1'b0;
    logic        step_req_b  = 1'b0;
    logic [7:0]  half_in_b   = 8'd0;
    logic        half_load_b = 1'b0;
    logic        halted_b;
    logic [7:0]  cur_half_b;
    logic [3:0]  cycle_count_b;

    typedef struct {
        logic        clk;
        logic        tick;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_count = 32'd0;

    cpu_clock_ctrl dut (
        .main_clk    (main_clk),
        .resetn      (resetn),
        .mem_clk     (mem_clk),
        .clock_out   (clock_out),
        .cpu_tick    (cpu_tick),
        .run_req     (run_req),
        .step_req    (step_req),
        .half_in     (half_in),
        .half_load   (half_load),
        .halted      (halted),
        .cur_half    (cur_half),
        .cycle_count (cycle_count)
    );

    // Small counter, starts halted, and a zero default ratio that must read back as 1.
    cpu_clock_ctrl #(
        .HALF_W       (8),
        .DEFAULT_HALF (0),
        .CNT_W        (4),
        .RESET_RUN    (1'b0)
    ) dut_b (
        .main_clk    (main_clk),
        .resetn      (resetn),
        .mem_clk     (mem_clk_b),
        .clock_out   (clock_out_b),
        .cpu_tick    (cpu_tick_b),
        .run_req     (run_req_b),
        .step_req    (step_req_b),
        .half_in     (half_in_b),
        .half_load   (half_load_b),
        .halted      (halted_b),
        .cur_half    (cur_half_b),
        .cycle_count (cycle_count_b)
    );

    always #5 main_clk = ~main_clk;

    task automatic next_cycle();
        @(posedge main_clk);
        #1;
    endtask

    task automatic push_pattern(input string c, input string t, input string h);
        exp_t e;
        for (int i = 0; i < c.len(); i++) begin
            if (t[i] == "1") exp_count = exp_count + 32'd1;
            e.clk    = (c[i] == "1");
            e.tick   = (t[i] == "1");
            e.halted = (h[i] == "1");
            e.count  = exp_count;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) next_cycle();
        checks++;
        if ({clock_out, cpu_tick, halted, cycle_count, cur_half} !== {1'b0, 1'b0, 1'b0, 32'd0, 8'd1}) begin
            failures++;
            $display("[TB] FAIL reset_a got clk=%b tick=%b halted=%b count=%0d half=%0d expected 0 0 0 0 1",
                     clock_out, cpu_tick, halted, cycle_count, cur_half);
        end
        checks++;
        if ({clock_out_b, cpu_tick_b, halted_b, cycle_count_b, cur_half_b} !== {1'b0, 1'b0, 1'b1, 4'd0, 8'd1}) begin
            failures++;
            $display("[TB] FAIL reset_b got clk=%b tick=%b halted=%b count=%0d half=%0d expected 0 0 1 0 1",
                     clock_out_b, cpu_tick_b, halted_b, cycle_count_b, cur_half_b);
        end
        checks++;
        if (mem_clk !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mem_clk_high got %b expected 1", mem_clk);
        end
        @(negedge main_clk);
        #1;
        checks++;
        if (mem_clk !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mem_clk_low got %b expected 0", mem_clk);
        end
        next_cycle();
        resetn    = 1'b1;
        exp_count = 32'd0;
        push_pattern("1010101010", "1010101010", "0000000000");
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL reset_run cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
        end
    endtask

    task automatic test_ratio_load();
        exp_t e;
        push_pattern("10001110001110", "10001000001000", "00000000000000");
        for (int i = 1; i <= 14; i++) begin
            if (i == 1) begin
                half_in   = 8'd3;
                half_load = 1'b1;
            end
            if (i == 2) half_load = 1'b0;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL ratio_load cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (cur_half !== ((i == 1) ? 8'd1 : 8'd3)) begin
                    failures++;
                    $display("[TB] FAIL ratio_half cycle %0d got %0d expected %0d", i, cur_half, (i == 1) ? 1 : 3);
                end
            end
        end
    endtask

    task automatic test_halt_align();
        exp_t e;
        push_pattern("001110000111100000000000",
                     "001000000100000000000000",
                     "000000000000000001111111");
        for (int i = 1; i <= 24; i++) begin
            if (i == 1) begin
                half_in   = 8'd4;
                half_load = 1'b1;
            end
            if (i == 2)  half_load = 1'b0;
            if (i == 12) run_req   = 1'b0;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL halt_align cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
            if (i == 6) begin
                checks++;
                if (cur_half !== 8'd4) begin
                    failures++;
                    $display("[TB] FAIL halt_half got %0d expected 4", cur_half);
                end
            end
        end
    endtask

    task automatic test_single_step();
        exp_t e;
        push_pattern("000011000000", "000010000000", "110000111111");
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) begin
                half_in   = 8'd2;
                half_load = 1'b1;
            end
            if (i == 2) half_load = 1'b0;
            if (i == 3) step_req  = 1'b1;
            if (i == 4) step_req  = 1'b0;
            if (i == 5) step_req  = 1'b1;
            if (i == 6) step_req  = 1'b0;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL single_step cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (cur_half !== ((i == 1) ? 8'd4 : 8'd2)) begin
                    failures++;
                    $display("[TB] FAIL halt_load cycle %0d got %0d expected %0d", i, cur_half, (i == 1) ? 4 : 2);
                end
            end
        end
    endtask

    task automatic test_step_to_run();
        exp_t e;
        push_pattern("001100110011", "001000100010", "000000000000");
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) step_req = 1'b1;
            if (i == 2) step_req = 1'b0;
            if (i == 3) run_req  = 1'b1;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL step_to_run cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] want_half;
        push_pattern("00110101", "00100101", "00000000");
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin
                half_in   = 8'd0;
                half_load = 1'b1;
            end
            if (i == 2) half_load = 1'b0;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL load_on_boundary cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
            want_half = (i >= 5) ? 8'd1 : 8'd2;
            checks++;
            if (cur_half !== want_half) begin
                failures++;
                $display("[TB] FAIL zero_half cycle %0d got %0d expected %0d", i, cur_half, want_half);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        push_pattern("010001", "010001", "000000");
        for (int i = 1; i <= 6; i++) begin
            if (i == 1) begin
                half_in   = 8'd3;
                half_load = 1'b1;
            end
            if (i == 2) half_load = 1'b0;
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL pre_reset cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({clock_out, cpu_tick, cycle_count, cur_half} !== {1'b0, 1'b0, 32'd0, 8'd1}) begin
            failures++;
            $display("[TB] FAIL async_reset got clk=%b tick=%b count=%0d half=%0d expected 0 0 0 1",
                     clock_out, cpu_tick, cycle_count, cur_half);
        end
        repeat (2) next_cycle();
        checks++;
        if ({clock_out, cpu_tick, halted} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_hold got clk=%b tick=%b halted=%b expected 0 0 0", clock_out, cpu_tick, halted);
        end
        resetn    = 1'b1;
        exp_count = 32'd0;
        push_pattern("1010", "1010", "0000");
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out, cpu_tick, halted, cycle_count} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL post_reset cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out, cpu_tick, halted, cycle_count, e.clk, e.tick, e.halted, e.count);
            end
        end
    endtask

    task automatic test_count_wrap();
        exp_t e;
        checks++;
        if ({halted_b, clock_out_b, cycle_count_b} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL wrap_start got halted=%b clk=%b count=%0d expected 1 0 0",
                     halted_b, clock_out_b, cycle_count_b);
        end
        for (int i = 1; i <= 34; i++) begin
            e.clk    = (i % 2 == 0);
            e.tick   = (i % 2 == 0);
            e.halted = 1'b0;
            e.count  = 32'((i / 2) % 16);
            sb.push_back(e);
        end
        run_req_b = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            next_cycle();
            e = sb.pop_front();
            checks++;
            if ({clock_out_b, cpu_tick_b, halted_b, {28'd0, cycle_count_b}} !== {e.clk, e.tick, e.halted, e.count}) begin
                failures++;
                $display("[TB] FAIL count_wrap cycle %0d got clk=%b tick=%b halted=%b count=%0d expected clk=%b tick=%b halted=%b count=%0d",
                         i, clock_out_b, cpu_tick_b, halted_b, cycle_count_b, e.clk, e.tick, e.halted, e.count);
            end
        end
        run_req_b = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at %0t with checks=%0d", $time, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_ratio_load();
        test_halt_align();
        test_single_step();
        test_step_to_run();
        test_back_to_back();
        test_async_reset();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Parametrised successor to the CPU/memory clock generator.
- Derives the CPU working clock from main_clk with a programmable even divide ratio, and passes main_clk through as mem_clk for memory read/write control.
- Adds run/halt/single-step control, a rising-edge tick pulse and a CPU cycle counter for the debug/IO path.
- Sits at top level between the board oscillator and the single-cycle CPU with IO.

Parameters:
- HALF_W, 8, width of the half-period register and counter.
- DEFAULT_HALF, 1, half-period in main_clk cycles after reset; DEFAULT_HALF=1 gives divide-by-2.
- CNT_W, 32, width of cycle_count.
- RESET_RUN, 1, 1: enter RUN after reset; 0: enter HALT after reset.

Ports:
- main_clk  in  1  sole clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- mem_clk  out  1  combinational copy of main_clk.
- clock_out  out  1  divided CPU clock (registered).
- cpu_tick  out  1  one main_clk-cycle pulse, coincident with each clock_out 0->1.
- run_req  in  1  level; 1 requests RUN, 0 requests HALT.
- step_req  in  1  pulse; requests one CPU cycle while halted.
- half_in  in  HALF_W  new half-period value.
- half_load  in  1  pulse; load half_in.
- halted  out  1  1 while in HALT with clock_out low.
- cur_half  out  HALF_W  half-period currently in effect.
- cycle_count  out  CNT_W  number of clock_out rising edges since reset; wraps.

Behaviour:
- Reset (resetn=0, async):
  - clock_out=0, cpu_tick=0, cycle_count=0, divide counter=0, pending load cleared.
  - cur_half=DEFAULT_HALF; a value of 0 is coerced to 1.
  - State = RESET_RUN ? RUN : HALT; halted=!RESET_RUN.
- Divider:
  - Counter runs 0..cur_half-1.
  - At cur_half-1: clock_out toggles and the counter returns to 0; otherwise the counter increments.
  - Period = 2*cur_half main_clk cycles; duty exactly 50%.
- cpu_tick: registered; asserted in the same cycle clock_out becomes 1; cycle_count increments in that same cycle.
- States:
  - RUN: divider active. If run_req=0, go to STOPPING.
  - STOPPING: divider active until clock_out would go 0->... (i.e. clock_out is low at a half-period boundary), then go to HALT. Never truncates a high phase.
  - HALT: counter held at 0, clock_out held 0, halted=1.
    - run_req=1 -> RUN. The first rising edge of clock_out occurs cur_half cycles later.
    - Else step_req=1 -> STEP.
  - STEP: divider active for exactly one full period (one rising and one falling edge, exactly one cpu_tick), then return to HALT.
    - run_req=1 during STEP: finish the period, then go to RUN without stopping.
  - step_req outside HALT is ignored (not queued).
- Divide-ratio load:
  - half_load latches half_in (0 coerced to 1) as pending.
  - In HALT, pending is applied on the next cycle.
  - Otherwise pending is applied at the next clock_out 1->0 boundary, so no glitch or short phase ever occurs.
  - A second half_load before application overwrites pending; last value wins.
- Simultaneous events:
  - half_load and a boundary in the same cycle: the new value is applied at the following 1->0 boundary.
  - step_req with run_req=1 in HALT: RUN wins.
- cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-phase: clock_out drops to 0 immediately (async); no cpu_tick is produced.

Test Plan:
- Reset defaults: RESET_RUN=1, DEFAULT_HALF=1 -> clock_out toggles every main_clk cycle; cpu_tick every 2nd cycle; cycle_count=5 after 10 main_clk cycles.
- Ratio load: half_in=3, half_load while running -> takes effect at the next 1->0 edge; thereafter period 6 cycles, 3 high/3 low; no phase shorter than the old half.
- Halt alignment: run_req=0 mid high-phase with cur_half=4 -> high phase completes (4 cycles), then clock_out stays 0 and halted=1; cycle_count frozen.
- Single step: in HALT with cur_half=2, step_req pulse -> exactly one cpu_tick, one 4-cycle period, then halted=1; cycle_count +1. A second step_req during STEP is ignored.
- Edge values: half_in=0 -> cur_half=1. With CNT_W=4, 17 rising edges -> cycle_count=1.
- Async reset mid-run: resetn low while clock_out=1 -> clock_out=0 same cycle; after release, state follows RESET_RUN and cur_half=DEFAULT_HALF.
